// File: rtl/cell_mem_arbiter_pkg.sv
// cell_mem_arbiter_pkg: shared cell coordinate width, edit FSM states and read-owner tags.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package cell_mem_arbiter_pkg;
    localparam int ADDR_W = `ADDR_WIDTH;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_RD   = 2'd1,
        E_WR   = 2'd2
    } edit_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_EDIT = 2'd2,
        OWN_EVO  = 2'd3
    } owner_e;
endpackage

// File: rtl/cell_edit_rmw.sv
// cell_edit_rmw: cursor toggle as an atomic read-modify-write of one board cell.
module cell_edit_rmw
    import cell_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = `ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                edit_toggle,
    input  logic [ADDR_W-1:0]   edit_x,
    input  logic [ADDR_W-1:0]   edit_y,
    input  logic                slot_gnt,
    input  logic                rd_ret,
    input  logic                rdata,
    output logic                slot_req,
    output logic                slot_we,
    output logic [2*ADDR_W-1:0] slot_addr,
    output logic                slot_wdata,
    output logic                busy
);
    edit_state_e state;
    logic        cap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= E_IDLE;
            slot_addr <= '0;
            cap       <= 1'b0;
        end else begin
            if (rd_ret) cap <= rdata;
            case (state)
                E_IDLE: if (edit_toggle) begin
                    slot_addr <= {edit_y, edit_x};
                    state     <= E_RD;
                end
                E_RD:    if (slot_gnt) state <= E_WR;
                E_WR:    if (slot_gnt) state <= E_IDLE;
                default: state <= E_IDLE;
            endcase
        end
    end

    assign slot_req   = (state == E_RD) || (state == E_WR);
    assign slot_we    = (state == E_WR);
    // a write in the cycle right after the read must use the bit still on the bus
    assign slot_wdata = ~(rd_ret ? rdata : cap);
    assign busy       = (state != E_IDLE);
endmodule

// File: rtl/cell_mem_arbiter.sv
// cell_mem_arbiter: display / edit / evolve sharing of the board RAM port.
module cell_mem_arbiter
    import cell_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int STARVE_LIMIT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                disp_req,
    input  logic [ADDR_W-1:0]   disp_x,
    input  logic [ADDR_W-1:0]   disp_y,
    output logic                disp_state,
    output logic                disp_valid,
    input  logic                edit_toggle,
    input  logic [ADDR_W-1:0]   edit_x,
    input  logic [ADDR_W-1:0]   edit_y,
    output logic                edit_busy,
    input  logic                evo_req,
    input  logic                evo_we,
    input  logic [ADDR_W-1:0]   evo_x,
    input  logic [ADDR_W-1:0]   evo_y,
    input  logic                evo_wdata,
    output logic                evo_gnt,
    output logic                evo_rvalid,
    output logic                evo_rdata,
    output logic [2*ADDR_W-1:0] mem_addr,
    output logic                mem_we,
    output logic                mem_wdata,
    input  logic                mem_rdata
);
    logic                edit_req, edit_we, edit_wdata, edit_sel, disp_sel, force_evo, disp_hold;
    logic [2*ADDR_W-1:0] edit_addr;
    owner_e              tag;

    cell_edit_rmw #(.ADDR_W(ADDR_W)) u_edit (
        .clk        (clk),
        .rst        (rst),
        .edit_toggle(edit_toggle),
        .edit_x     (edit_x),
        .edit_y     (edit_y),
        .slot_gnt   (edit_sel),
        .rd_ret     (tag == OWN_EDIT),
        .rdata      (mem_rdata),
        .slot_req   (edit_req),
        .slot_we    (edit_we),
        .slot_addr  (edit_addr),
        .slot_wdata (edit_wdata),
        .busy       (edit_busy)
    );

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_cnt <= '0;
        else if (evo_gnt) starve_cnt <= '0;
        else if (evo_req && starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
    end

    assign force_evo = evo_req && !edit_req && (int'(starve_cnt) >= STARVE_LIMIT);
`else
    assign force_evo = 1'b0;
`endif

    assign disp_sel  = disp_req && !force_evo;
    assign edit_sel  = !disp_sel && edit_req;
    assign evo_gnt   = !disp_sel && !edit_req && evo_req;
    assign mem_addr  = disp_sel ? {disp_y, disp_x} : edit_sel ? edit_addr : evo_gnt ? {evo_y, evo_x} : '0;
    assign mem_we    = edit_sel ? edit_we : evo_gnt && evo_we;
    assign mem_wdata = edit_sel ? edit_wdata : evo_gnt && evo_we && evo_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag       <= OWN_NONE;
            disp_hold <= 1'b0;
        end else begin
            tag       <= disp_sel ? OWN_DISP : (edit_sel && !edit_we) ? OWN_EDIT :
                         (evo_gnt && !evo_we) ? OWN_EVO : OWN_NONE;
            disp_hold <= disp_state;
        end
    end

    assign disp_valid = (tag == OWN_DISP);
    assign disp_state = disp_valid ? mem_rdata : disp_hold;
    assign evo_rvalid = (tag == OWN_EVO);
    assign evo_rdata  = evo_rvalid && mem_rdata;
endmodule

// File: tb/tb_cell_mem_arbiter.sv
// tb_cell_mem_arbiter: directed checks of slot priority, edit RMW, evolve access and reset.
module tb_cell_mem_arbiter;
    logic        clk = 1'b0, rst;
    logic        disp_req, edit_toggle, evo_req, evo_we, evo_wdata;
    logic [7:0]  disp_x, disp_y, edit_x, edit_y, evo_x, evo_y;
    logic        disp_state, disp_valid, edit_busy, evo_gnt, evo_rvalid, evo_rdata;
    logic [15:0] mem_addr;
    logic        mem_we, mem_wdata, mem_rdata;
    logic        ram [65536];
    int          errs = 0, checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    cell_mem_arbiter #(.ADDR_W(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_state(disp_state), .disp_valid(disp_valid),
        .edit_toggle(edit_toggle), .edit_x(edit_x), .edit_y(edit_y), .edit_busy(edit_busy),
        .evo_req(evo_req), .evo_we(evo_we), .evo_x(evo_x), .evo_y(evo_y), .evo_wdata(evo_wdata),
        .evo_gnt(evo_gnt), .evo_rvalid(evo_rvalid), .evo_rdata(evo_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; mem_rdata = 1'b0;
        disp_req = 0; edit_toggle = 0; evo_req = 0; evo_we = 0; evo_wdata = 0;
        disp_x = 0; disp_y = 0; edit_x = 0; edit_y = 0; evo_x = 0; evo_y = 0;
        for (int i = 0; i < 65536; i++) ram[i] = 1'b0;
        ram[16'h0705] = 1'b1;
        ram[16'h0902] = 1'b1;
        repeat (2) tick;
        chk("reset_outputs", {disp_state, disp_valid, edit_busy, evo_rvalid, evo_rdata}, 16'h0);
        rst = 1'b1;
        disp_req = 1; disp_x = 5; disp_y = 7; evo_req = 1; evo_we = 0; evo_x = 2; evo_y = 9; #1;
        chk("disp_addr", mem_addr, 16'h0705);
        chk("disp_blocks_evo", evo_gnt, 0);
        tick; disp_req = 0; #1;
        chk("disp_state", disp_state, 1);
        chk("disp_valid", disp_valid, 1);
        chk("evo_gnt_idle", evo_gnt, 1);
        chk("evo_addr", mem_addr, 16'h0902);
        tick; evo_req = 0; #1;
        chk("evo_rvalid", evo_rvalid, 1);
        chk("evo_rdata", evo_rdata, 1);
        chk("disp_valid_off", disp_valid, 0);
        chk("disp_state_hold", disp_state, 1);
        tick; #1;
        chk("evo_rvalid_pulse", evo_rvalid, 0);
        edit_toggle = 1; edit_x = 3; edit_y = 4; #1;
        chk("edit_busy_t0", edit_busy, 0);
        chk("idle_we", mem_we, 0);
        chk("idle_addr", mem_addr, 16'h0000);
        tick; edit_x = 8; #1;
        chk("edit_busy_t1", edit_busy, 1);
        chk("edit_rd_addr", mem_addr, 16'h0403);
        chk("edit_rd_we", mem_we, 0);
        tick; edit_toggle = 0; #1;
        chk("edit_wr_we", mem_we, 1);
        chk("edit_wr_data", mem_wdata, 1);
        chk("edit_wr_addr", mem_addr, 16'h0403);
        tick; #1;
        chk("edit_busy_t3", edit_busy, 0);
        chk("edit_cell", ram[16'h0403], 1);
        chk("edit_no_queue_we", mem_we, 0);
        tick; #1;
        chk("edit_no_queue_busy", edit_busy, 0);
        edit_toggle = 1; edit_x = 3; #1;
        tick; edit_toggle = 0; evo_req = 1; evo_we = 1; evo_wdata = 1; evo_x = 3; evo_y = 4; #1;
        chk("atomic_rd_gnt", evo_gnt, 0);
        tick; #1;
        chk("atomic_wr_gnt", evo_gnt, 0);
        chk("atomic_wr_we", mem_we, 1);
        chk("atomic_wr_data", mem_wdata, 0);
        tick; #1;
        chk("atomic_evo_gnt", evo_gnt, 1);
        chk("atomic_evo_data", mem_wdata, 1);
        tick; evo_req = 0; evo_we = 0; evo_wdata = 0; #1;
        chk("atomic_cell", ram[16'h0403], 1);
        chk("atomic_busy", edit_busy, 0);
        edit_toggle = 1; evo_req = 1; #1;
        chk("simul_evo_gnt", evo_gnt, 1);
        tick; edit_toggle = 0; evo_req = 0; #1;
        chk("simul_rdata", {evo_rvalid, evo_rdata}, 16'h3);
        chk("simul_busy", edit_busy, 1);
        chk("simul_edit_addr", mem_addr, 16'h0403);
        tick; #1;
        chk("simul_wr", {mem_we, mem_wdata}, 16'h2);
        tick; #1;
        chk("simul_cell", ram[16'h0403], 0);
        edit_toggle = 1; evo_req = 1; evo_x = 2; evo_y = 9; #1;
        tick; edit_toggle = 0; evo_req = 0; #1;
        chk("mid_busy", edit_busy, 1);
        chk("mid_rvalid", evo_rvalid, 1);
        rst = 1'b0; #1;
        chk("mid_reset_outputs", {disp_state, disp_valid, edit_busy, evo_rvalid, evo_rdata}, 16'h0);
        tick; rst = 1'b1; #1;
        chk("post_reset", {evo_rvalid, edit_busy, mem_we}, 16'h0);
        tick; #1;
        chk("post_reset_cell", ram[16'h0403], 0);
        chk("post_reset_busy", edit_busy, 0);
`ifdef ARB_STARVE_GUARD_EN
        disp_req = 1; disp_x = 5; disp_y = 7; evo_req = 1; evo_we = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("starve_wait", evo_gnt, 0);
            tick;
        end
        #1;
        chk("starve_force_gnt", evo_gnt, 1);
        chk("starve_force_addr", mem_addr, 16'h0902);
        tick; evo_req = 0; #1;
        chk("starve_disp_valid", disp_valid, 0);
        chk("starve_disp_hold", disp_state, 1);
        chk("starve_rvalid", evo_rvalid, 1);
        tick; #1;
        chk("starve_disp_back", disp_valid, 1);
        disp_req = 0;
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cell_mem_arbiter.md
Name: cell_mem_arbiter

Overview:
- Shares one single-port, synchronous-read cell board RAM between three requesters:
  - the display path, which reads the cell under the VGA scan position;
  - the edit cursor, which toggles one cell with a read-modify-write;
  - the evolution engine, which does generation sweeps of reads and writes.
- Sits between envolve_display_ctrl / evolution engine / cursor logic and the board RAM.
- Display is never stalled. Edit is atomic. Evolve uses the remaining slots.

Parameters:
- ADDR_W, 8, bits per cell coordinate. Matches `ADDR_WIDTH.
- STARVE_LIMIT, 255, max consecutive cycles evo_req may wait before a forced grant (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- disp_req  in  1  display read request (driven by in_disp_area)
- disp_x, disp_y  in  ADDR_W  display cell coordinate
- disp_state  out  1  registered cell state for the display
- disp_valid  out  1  disp_state refreshed this cycle
- edit_toggle  in  1  single-cycle pulse: invert cell (edit_x, edit_y)
- edit_x, edit_y  in  ADDR_W  cursor cell coordinate
- edit_busy  out  1  toggle in progress; new pulses are dropped
- evo_req  in  1  evolve access request, held until granted
- evo_we  in  1  1 = write, 0 = read
- evo_x, evo_y  in  ADDR_W  evolve cell coordinate
- evo_wdata  in  1  evolve write data
- evo_gnt  out  1  combinational: evolve access issued this cycle
- evo_rvalid  out  1  evo_rdata valid (cycle after a granted read)
- evo_rdata  out  1  evolve read data
- mem_addr  out  2*ADDR_W  {y, x}
- mem_we  out  1  RAM write enable
- mem_wdata  out  1  RAM write data
- mem_rdata  in  1  RAM read data, 1-cycle latency

Behaviour:
- Reset (rst low, asynchronous):
  - all registered outputs 0;
  - edit FSM to E_IDLE;
  - returning read-owner tag cleared.
- Slot priority each cycle, highest first:
  1. display, when disp_req;
  2. edit FSM, when in E_RD or E_WR;
  3. evolve, when evo_req.
- An idle slot drives mem_we=0 and mem_addr=0.
- The memory port is combinational from the slot decision.
- A 2-bit owner tag is registered with each read and steers mem_rdata on the next cycle.
- Display read:
  - issued in cycle t;
  - disp_state and disp_valid are updated in cycle t+1;
  - disp_state holds its value when there is no display read.
- Edit FSM:
  - E_IDLE: edit_toggle=1 latches edit_x and edit_y → E_RD, and edit_busy=1 from the next cycle.
  - E_RD: on winning a slot, issue the read → E_WR. The returned bit is captured in t+1.
  - E_WR: on winning a slot (at the earliest t+1), write the inverted captured bit → E_IDLE, and edit_busy=0 the next cycle.
  - Evolve is never granted while the FSM is in E_RD or E_WR, so the read-modify-write is atomic against evolve writes.
  - A toggle pulse while edit_busy=1 is ignored. It is not queued.
- Evolve:
  - evo_gnt=1 only in a cycle where the evolve access drives the RAM.
  - The requester must hold all evo_* inputs stable until evo_gnt.
  - Read data: evo_rvalid pulses for 1 cycle at t+1, with evo_rdata.
  - A write completes in the grant cycle.
- Simultaneous events:
  - edit_toggle in the same cycle as a pending evo_req: the edit is latched, and evolve still wins that cycle's slot if display is idle. The FSM enters E_RD only from the next cycle.
  - disp_req high every cycle: edit and evolve stall indefinitely. This is intended; the blanking intervals provide the slots.
- Reset mid-operation: an in-flight toggle is abandoned (the cell is unchanged if the write had not yet issued). Any pending rvalid is suppressed.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With it defined:
  - an 8-bit counter increments while evo_req=1 and evo_gnt=0;
  - when the count reaches STARVE_LIMIT, the next slot goes to evolve even over display. Edit in E_RD/E_WR still outranks evolve, so the forced grant waits until the edit FSM is idle;
  - on a forced grant, disp_valid=0 on the following cycle and disp_state holds;
  - the counter clears on any evo_gnt.
- Without it: no counter, and display has strict priority.

Decomposition:
- Shared defines package holds:
  - ADDR_W / `ADDR_WIDTH;
  - edit FSM state encodings (E_IDLE=2'd0, E_RD=2'd1, E_WR=2'd2);
  - owner tag encodings (OWN_NONE, OWN_DISP, OWN_EDIT, OWN_EVO).
- One sub-module: cell_edit_rmw, the edit FSM plus capture register, exposing slot_req, slot_we, slot_addr and slot_wdata to the top-level priority mux.

Test Plan:
- Reset: rst low mid-traffic → all outputs 0, edit_busy=0, no evo_rvalid the cycle after release.
- Display only: disp_req=1, (x,y)=(5,7), RAM cell=1 → mem_addr=16'h0705 in cycle t; disp_state=1 and disp_valid=1 in t+1; evo_gnt stays 0 while evo_req=1.
- Edit toggle: cell (3,4)=0, display idle, edit_toggle pulse → read at t+1, write mem_wdata=1 at t+2, edit_busy low at t+3. A second pulse at t+1 is ignored.
- Atomic edit: evo_req write of 1 to (3,4), held through the toggle → evo_gnt only after the edit write completes; final cell=1.
- Evolve read: display idle, evo_req=1, evo_we=0 on cell=1 → evo_gnt=1 same cycle; evo_rvalid=1 and evo_rdata=1 the next cycle.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: disp_req held high, evo_req=1 → evo_gnt on the 5th cycle; disp_valid=0 in the following cycle.
